// File: rtl/mmio_fifo_pkg.sv
// Shared register map constants for the MMIO FIFO bank: per-channel offsets,
// STATUS bit positions and STATUS-write control bits.
package mmio_fifo_pkg;

    localparam logic [2:0] OFF_DATA   = 3'd0;
    localparam logic [2:0] OFF_STATUS = 3'd2;
    localparam logic [2:0] OFF_PEEK   = 3'd4;
    localparam int         CH_STRIDE  = 8;

    localparam int ST_COUNT_W = 16;
    localparam int ST_EMPTY   = 16;
    localparam int ST_FULL    = 17;
    localparam int ST_OVF     = 18;
    localparam int ST_UNF     = 19;

    localparam int CTL_FLUSH   = 0;
    localparam int CTL_CLR_ERR = 1;

    function automatic logic [63:0] status_word(
        input logic [ST_COUNT_W-1:0] count,
        input logic                  empty,
        input logic                  full,
        input logic                  ovf,
        input logic                  unf
    );
        logic [63:0] w;
        w                   = '0;
        w[ST_COUNT_W-1:0]   = count;
        w[ST_EMPTY]         = empty;
        w[ST_FULL]          = full;
        w[ST_OVF]           = ovf;
        w[ST_UNF]           = unf;
        return w;
    endfunction

endpackage

// File: rtl/mmio_fifo_ch.sv
// One circular FIFO channel: storage, wrapping pointers, occupancy count and
// sticky overflow/underflow flags. Pop decisions use the pre-edge state.
module mmio_fifo_ch
    import mmio_fifo_pkg::*;
#(
    parameter  int DATA_W = 64,
    parameter  int DEPTH  = 8,
    localparam int CNT_W  = $clog2(DEPTH + 1),
    localparam int PTR_W  = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    input  logic              flush,
    input  logic              clr_err,
    output logic [DATA_W-1:0] head,
    output logic [CNT_W-1:0]  count,
    output logic              empty,
    output logic              full,
    output logic              overflow,
    output logic              underflow
);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              ovf_q, ovf_d;
    logic              unf_q, unf_d;
    logic              is_empty, is_full, push_ok, pop_ok;

    always_comb begin
        is_empty = (count_q == '0);
        is_full  = (count_q == CNT_W'(DEPTH));
        pop_ok   = pop && !is_empty;
        // A pop in the same cycle frees a slot, so a push into a full FIFO is accepted.
        push_ok  = push && (!is_full || pop);

        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        ovf_d    = ovf_q;
        unf_d    = unf_q;

        if (push_ok) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (pop_ok)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
        count_d = count_q + CNT_W'(push_ok) - CNT_W'(pop_ok);

        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end

        // Clearing wins over an error raised in the same cycle.
        if (clr_err) begin
            ovf_d = 1'b0;
            unf_d = 1'b0;
        end else begin
            ovf_d = ovf_q | (push && is_full && !pop);
            unf_d = unf_q | (pop && is_empty);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
            unf_q    <= unf_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q] <= push_data;
    end

    assign head      = mem_q[rd_ptr_q];
    assign count     = count_q;
    assign empty     = is_empty;
    assign full      = is_full;
    assign overflow  = ovf_q;
    assign underflow = unf_q;

endmodule

// File: rtl/mmio_fifo_bank.sv
// MMIO window of NUM_CH independent FIFOs: address decode plus registered read
// response. Define MMIO_FIFO_BANK_PEEK_EN to implement the non-popping PEEK register.
module mmio_fifo_bank
    import mmio_fifo_pkg::*;
#(
    parameter int DATA_W    = 64,
    parameter int DEPTH     = 8,
    parameter int NUM_CH    = 4,
    parameter int BASE_ADDR = 16'h0020,
    parameter int ADDR_W    = 16,
    parameter int TID_W     = 9
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mmio_wr_valid,
    input  logic [ADDR_W-1:0] mmio_wr_addr,
    input  logic [63:0]       mmio_wr_data,
    input  logic              mmio_rd_valid,
    input  logic [ADDR_W-1:0] mmio_rd_addr,
    input  logic [TID_W-1:0]  mmio_rd_tid,
    output logic              rsp_valid,
    output logic [TID_W-1:0]  rsp_tid,
    output logic [63:0]       rsp_data,
    output logic [NUM_CH-1:0] ch_empty,
    output logic [NUM_CH-1:0] ch_full
);

    localparam int                CH_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int                CNT_W    = $clog2(DEPTH + 1);
    localparam logic [ADDR_W-1:0] WIN_BASE = ADDR_W'(BASE_ADDR);
    localparam logic [ADDR_W-1:0] WIN_SIZE = ADDR_W'(CH_STRIDE * NUM_CH);

    logic [ADDR_W-1:0] wr_off, rd_off;
    logic              wr_hit, rd_hit;
    logic [CH_W-1:0]   wr_ch, rd_ch;
    logic [2:0]        wr_reg, rd_reg;

    logic [NUM_CH-1:0] push, pop, flush, clr_err, ovf, unf;
    logic [DATA_W-1:0] head  [NUM_CH];
    logic [CNT_W-1:0]  count [NUM_CH];

    logic              rsp_valid_q, rsp_valid_d;
    logic [TID_W-1:0]  rsp_tid_q, rsp_tid_d;
    logic [63:0]       rsp_data_q, rsp_data_d;

    always_comb begin
        wr_off = mmio_wr_addr - WIN_BASE;
        rd_off = mmio_rd_addr - WIN_BASE;
        wr_hit = mmio_wr_valid && (mmio_wr_addr >= WIN_BASE) && (wr_off < WIN_SIZE);
        rd_hit = mmio_rd_valid && (mmio_rd_addr >= WIN_BASE) && (rd_off < WIN_SIZE);
        wr_ch  = wr_off[3 +: CH_W];
        rd_ch  = rd_off[3 +: CH_W];
        wr_reg = wr_off[2:0];
        rd_reg = rd_off[2:0];
    end

    always_comb begin
        push    = '0;
        pop     = '0;
        flush   = '0;
        clr_err = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (wr_hit && wr_ch == CH_W'(c)) begin
                push[c]    = (wr_reg == OFF_DATA);
                flush[c]   = (wr_reg == OFF_STATUS) && mmio_wr_data[CTL_FLUSH];
                clr_err[c] = (wr_reg == OFF_STATUS) && mmio_wr_data[CTL_CLR_ERR];
            end
            if (rd_hit && rd_ch == CH_W'(c)) pop[c] = (rd_reg == OFF_DATA);
        end
    end

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        mmio_fifo_ch #(
            .DATA_W (DATA_W),
            .DEPTH  (DEPTH)
        ) u_ch (
            .clk       (clk),
            .rst       (rst),
            .push      (push[c]),
            .push_data (mmio_wr_data[DATA_W-1:0]),
            .pop       (pop[c]),
            .flush     (flush[c]),
            .clr_err   (clr_err[c]),
            .head      (head[c]),
            .count     (count[c]),
            .empty     (ch_empty[c]),
            .full      (ch_full[c]),
            .overflow  (ovf[c]),
            .underflow (unf[c])
        );
    end

    // Read data is taken from pre-edge channel state; empty channels return 0.
    always_comb begin
        rsp_valid_d = rd_hit;
        rsp_tid_d   = rd_hit ? mmio_rd_tid : '0;
        rsp_data_d  = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (rd_hit && rd_ch == CH_W'(c)) begin
                case (rd_reg)
                    OFF_DATA: begin
                        if (!ch_empty[c]) rsp_data_d[DATA_W-1:0] = head[c];
                    end
                    OFF_STATUS: begin
                        rsp_data_d = status_word(ST_COUNT_W'(count[c]), ch_empty[c],
                                                 ch_full[c], ovf[c], unf[c]);
                    end
`ifdef MMIO_FIFO_BANK_PEEK_EN
                    OFF_PEEK: begin
                        if (!ch_empty[c]) rsp_data_d[DATA_W-1:0] = head[c];
                    end
`endif
                    default: rsp_data_d = '0;
                endcase
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsp_valid_q <= 1'b0;
            rsp_tid_q   <= '0;
            rsp_data_q  <= '0;
        end else begin
            rsp_valid_q <= rsp_valid_d;
            rsp_tid_q   <= rsp_tid_d;
            rsp_data_q  <= rsp_data_d;
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_tid   = rsp_tid_q;
    assign rsp_data  = rsp_data_q;

endmodule

// File: tb/tb_mmio_fifo_bank.sv
// Scoreboard bench for mmio_fifo_bank: queue-per-channel reference model,
// directed register-map scenarios followed by randomized MMIO traffic.
module tb_mmio_fifo_bank;

    localparam int DATA_W = 64;
    localparam int DEPTH  = 8;
    localparam int NUM_CH = 4;
    localparam int BASE   = 16'h0020;
    localparam int ADDR_W = 16;
    localparam int TID_W  = 9;
    localparam int EXP_W  = TID_W + 64;

    logic              clk = 1'b0;
    logic              rst;
    logic              mmio_wr_valid;
    logic [ADDR_W-1:0] mmio_wr_addr;
    logic [63:0]       mmio_wr_data;
    logic              mmio_rd_valid;
    logic [ADDR_W-1:0] mmio_rd_addr;
    logic [TID_W-1:0]  mmio_rd_tid;
    logic              rsp_valid;
    logic [TID_W-1:0]  rsp_tid;
    logic [63:0]       rsp_data;
    logic [NUM_CH-1:0] ch_empty;
    logic [NUM_CH-1:0] ch_full;

    mmio_fifo_bank #(
        .DATA_W    (DATA_W),
        .DEPTH     (DEPTH),
        .NUM_CH    (NUM_CH),
        .BASE_ADDR (BASE),
        .ADDR_W    (ADDR_W),
        .TID_W     (TID_W)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .mmio_wr_valid (mmio_wr_valid),
        .mmio_wr_addr  (mmio_wr_addr),
        .mmio_wr_data  (mmio_wr_data),
        .mmio_rd_valid (mmio_rd_valid),
        .mmio_rd_addr  (mmio_rd_addr),
        .mmio_rd_tid   (mmio_rd_tid),
        .rsp_valid     (rsp_valid),
        .rsp_tid       (rsp_tid),
        .rsp_data      (rsp_data),
        .ch_empty      (ch_empty),
        .ch_full       (ch_full)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    logic [63:0]      mq  [NUM_CH][$];
    logic             ovf [NUM_CH];
    logic             unf [NUM_CH];
    logic [EXP_W-1:0] exp_q[$];
    int               n_checks = 0;
    int               n_fail   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int c = 0; c < NUM_CH; c++) begin
            mq[c].delete();
            ovf[c] = 1'b0;
            unf[c] = 1'b0;
        end
    endtask

    function automatic logic in_window(input logic [ADDR_W-1:0] a);
        return (int'(a) >= BASE) && (int'(a) < BASE + 8 * NUM_CH);
    endfunction

    task automatic model_read(input logic [ADDR_W-1:0] a, output logic v, output logic [63:0] d);
        int ch, off, n;
        v = in_window(a);
        d = '0;
        if (v) begin
            ch = (int'(a) - BASE) / 8;
            off = (int'(a) - BASE) % 8;
            n = mq[ch].size();
            if (off == 0) begin
                if (n > 0) d = mq[ch].pop_front();
                else unf[ch] = 1'b1;
            end else if (off == 2) begin
                d = 64'(n) + ((n == 0) ? 64'h10000 : 64'h0) + ((n == DEPTH) ? 64'h20000 : 64'h0)
                  + (ovf[ch] ? 64'h40000 : 64'h0) + (unf[ch] ? 64'h80000 : 64'h0);
            end else if (off == 4) begin
`ifdef MMIO_FIFO_BANK_PEEK_EN
                if (n > 0) d = mq[ch][0];
`endif
            end
        end
    endtask

    task automatic model_write(input logic [ADDR_W-1:0] a, input logic [63:0] d);
        int ch, off;
        if (in_window(a)) begin
            ch = (int'(a) - BASE) / 8;
            off = (int'(a) - BASE) % 8;
            if (off == 0) begin
                if (mq[ch].size() < DEPTH) mq[ch].push_back(d);
                else ovf[ch] = 1'b1;
            end else if (off == 2) begin
                if (d[0]) mq[ch].delete();
                if (d[1]) begin
                    ovf[ch] = 1'b0;
                    unf[ch] = 1'b0;
                end
            end
        end
    endtask

    task automatic chk_flags();
        logic [NUM_CH-1:0] e, f;
        for (int c = 0; c < NUM_CH; c++) begin
            e[c] = (mq[c].size() == 0);
            f[c] = (mq[c].size() == DEPTH);
        end
        chk("ch_empty", 64'(ch_empty), 64'(e));
        chk("ch_full", 64'(ch_full), 64'(f));
    endtask

    // ---------------- driver tasks ----------------
    // One bus cycle: read is modelled before the write so it sees pre-cycle state.
    task automatic cycle(input logic wv, input logic [ADDR_W-1:0] wa, input logic [63:0] wd,
                         input logic rv, input logic [ADDR_W-1:0] ra);
        logic             ev;
        logic [63:0]      ed;
        logic [TID_W-1:0] tid;
        tid           = TID_W'($urandom_range(0, (1 << TID_W) - 1));
        mmio_wr_valid = wv;
        mmio_wr_addr  = wa;
        mmio_wr_data  = wd;
        mmio_rd_valid = rv;
        mmio_rd_addr  = ra;
        mmio_rd_tid   = tid;
        ev = 1'b0;
        ed = '0;
        if (rv) model_read(ra, ev, ed);
        if (wv) model_write(wa, wd);
        @(posedge clk);
        #1;
        if (ev) exp_q.push_back({tid, ed});
        mmio_wr_valid = 1'b0;
        mmio_rd_valid = 1'b0;
        @(negedge clk);
        chk_flags();
    endtask

    task automatic wr(input logic [ADDR_W-1:0] a, input logic [63:0] d);
        cycle(1'b1, a, d, 1'b0, '0);
    endtask

    task automatic rd(input logic [ADDR_W-1:0] a);
        cycle(1'b0, '0, '0, 1'b1, a);
    endtask

    function automatic logic [ADDR_W-1:0] rand_addr();
        int ch, sel;
        ch  = $urandom_range(0, NUM_CH - 1);
        sel = $urandom_range(0, 19);
        if (sel < 10)      return ADDR_W'(BASE + 8 * ch);
        else if (sel < 13) return ADDR_W'(BASE + 8 * ch + 2);
        else if (sel < 15) return ADDR_W'(BASE + 8 * ch + 4);
        else if (sel < 18) return ADDR_W'(BASE + 8 * ch + $urandom_range(0, 7));
        else if (sel < 19) return ADDR_W'($urandom_range(0, BASE - 1));
        else               return ADDR_W'($urandom_range(BASE + 8 * NUM_CH, 16'hFFFF));
    endfunction

    // ---------------- scoreboard monitor ----------------
    always @(negedge clk) begin
        logic [EXP_W-1:0] e;
        chk("rsp_valid", 64'(rsp_valid), 64'(exp_q.size() != 0));
        if (rsp_valid && exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk("rsp_tid", 64'(rsp_tid), 64'(e[EXP_W-1:64]));
            chk("rsp_data", rsp_data, e[63:0]);
        end else if (exp_q.size() != 0) begin
            exp_q.delete();
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        logic [ADDR_W-1:0] a;
        rst = 1'b1;
        mmio_wr_valid = 1'b0;
        mmio_wr_addr  = '0;
        mmio_wr_data  = '0;
        mmio_rd_valid = 1'b0;
        mmio_rd_addr  = '0;
        mmio_rd_tid   = '0;
        model_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("reset_rsp_tid", 64'(rsp_tid), 64'd0);
        chk("reset_rsp_data", rsp_data, 64'd0);
        chk("reset_ch_empty", 64'(ch_empty), 64'hF);
        chk("reset_ch_full", 64'(ch_full), 64'h0);
        rst = 1'b0;

        rd(16'h0022);

        wr(16'h0028, 64'hA);
        wr(16'h0028, 64'hB);
        wr(16'h0028, 64'hC);
        repeat (4) rd(16'h0028);
        rd(16'h002A);

        for (int i = 0; i < DEPTH + 1; i++) wr(16'h0020, {$urandom, $urandom});
        rd(16'h0022);
        for (int i = 0; i < DEPTH; i++) rd(16'h0020);
        for (int i = 0; i < 3 * DEPTH; i++) begin
            wr(16'h0020, {$urandom, $urandom});
            rd(16'h0020);
        end
        rd(16'h0022);

        wr(16'h0038, 64'h55);
        rd(16'h0038);

        for (int i = 0; i < DEPTH; i++) wr(16'h0030, 64'(100 + i));
        cycle(1'b1, 16'h0030, 64'h1234, 1'b1, 16'h0030);
        rd(16'h0032);
        wr(16'h0032, 64'h3);
        rd(16'h0032);

        wr(16'h0020, 64'h77);
        rd(16'h0024);
        rd(16'h0022);
        rd(16'h0000);
        wr(16'h0022, 64'h1);

        wr(16'h0028, 64'h11);
        wr(16'h0028, 64'h22);
        cycle(1'b1, 16'h002A, 64'h1, 1'b1, 16'h0028);
        rd(16'h002A);
        cycle(1'b1, 16'h0028, 64'h99, 1'b1, 16'h0028);
        rd(16'h002A);
        wr(16'h002A, 64'h3);

        for (int i = 0; i < 800; i++) begin
            a = rand_addr();
            if (a[2:0] == 3'd2 && $urandom_range(0, 3) != 0)
                a = ADDR_W'(BASE + 8 * $urandom_range(0, NUM_CH - 1));
            cycle(1'($urandom_range(0, 1)), a, {$urandom, $urandom},
                  1'($urandom_range(0, 1)), rand_addr());
        end

        wr(16'h0020, 64'h5);
        wr(16'h0030, 64'h6);
        #2;
        rst = 1'b1;
        model_reset();
        #1;
        chk("midreset_ch_empty", 64'(ch_empty), 64'hF);
        chk("midreset_rsp_valid", 64'(rsp_valid), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        rd(16'h0022);
        rd(16'h0032);
        repeat (2) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mmio_fifo_bank.md
# mmio_fifo_bank

Parametrised bank of NUM_CH independent circular FIFOs exposed through MMIO, the successor to the single fixed-depth MMIO FIFO in the ccip_mmio AFU. Host MMIO writes push, MMIO reads pop, and each channel has a status/control register that reports occupancy and sticky error flags and supports flush. The block sits behind the AFU's CCI-P MMIO decode. The AFU top keeps the DFH/AFU_ID registers and muxes this block's response into tx.c2.

## Interface
- DATA_W, 64: FIFO entry width, 1..64.
- DEPTH, 8: entries per channel, power of two, ≥2.
- NUM_CH, 4: number of channels, 1..16.
- BASE_ADDR, 16'h0020: first MMIO word address of the window, aligned to 8.
- ADDR_W, 16: MMIO address width.
- TID_W, 9: MMIO transaction-ID width.
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- mmio_wr_valid  in  1  MMIO write strobe.
- mmio_wr_addr  in  ADDR_W  write word address.
- mmio_wr_data  in  64  write data.
- mmio_rd_valid  in  1  MMIO read strobe.
- mmio_rd_addr  in  ADDR_W  read word address.
- mmio_rd_tid  in  TID_W  read transaction ID.
- rsp_valid  out  1  read response valid; asserted only for window hits.
- rsp_tid  out  TID_W  echoed TID.
- rsp_data  out  64  read response data.
- ch_empty  out  NUM_CH  per-channel empty.
- ch_full  out  NUM_CH  per-channel full.

## Operation
- Window: BASE_ADDR .. BASE_ADDR+8*NUM_CH-1. Channel c is at offset 8c.
  - +0 DATA: write pushes mmio_wr_data[DATA_W-1:0]; read pops the head and returns it zero-extended to 64.
  - +2 STATUS: read returns [15:0] count, [16] empty, [17] full, [18] overflow, [19] underflow, all other bits 0. A write with bit0=1 flushes (count=0). A write with bit1=1 clears both sticky flags. Both bits may be set in one write.
  - +4 PEEK (only with macro): read returns the head without popping.
  - Any other in-window address reads 0 with rsp_valid=1. Writes to it are ignored.
- Push when full: data is dropped, overflow sets, count is unchanged.
- Pop when empty: returns 0, underflow sets, pointers are unchanged.
- A write and a read in the same cycle are both processed. The read sees the pre-cycle state.
  - Same channel, push + pop: when full, the pop succeeds, the push is accepted, and count is unchanged with no overflow. When empty, the read returns 0 with underflow set and the push lands (count=1).
  - Flush + pop on the same channel: the read returns the pre-flush head, count ends at 0, and underflow is not set.
- Count width is $clog2(DEPTH+1). Read/write pointers are $clog2(DEPTH) bits and wrap modulo DEPTH.
- Out-of-window reads: rsp_valid stays 0 and no state changes.

## Timing
- Read response arrives 1 cycle after mmio_rd_valid, as registered rsp_valid/rsp_tid/rsp_data. rsp_valid is a one-cycle pulse per request. Back-to-back reads give back-to-back responses.
- Push/pop/flush take effect at the edge that samples the strobe. ch_empty/ch_full/count reflect the change in the next cycle.
- Reset values: all FIFOs empty, sticky flags 0, rsp_valid=0, rsp_tid=0, rsp_data=0, ch_empty all 1, ch_full all 0.
- Reset mid-operation discards all contents and any pending response. Storage contents need not be cleared.

## Configuration
- MMIO_FIFO_BANK_PEEK_EN defined: the +4 PEEK register is implemented.
- Not defined: +4 reads return 0 with rsp_valid=1, and no peek mux is synthesised.

## Structure
- Package mmio_fifo_pkg holds:
  - Offsets: OFF_DATA=0, OFF_STATUS=2, OFF_PEEK=4, CH_STRIDE=8.
  - STATUS bit positions.
  - Control bit positions: FLUSH=0, CLR_ERR=1.
- Sub-module mmio_fifo_ch implements one channel's circular buffer, pointers, count and sticky flags, with push/pop/flush/clr inputs and head/count/flags outputs. The top is generated NUM_CH times and adds address decode and the registered response mux.

## Test plan
- Reset then read STATUS ch0 at 0x0022 → rsp_valid one cycle later, data=0x10000 (empty, count 0), TID echoed.
- Push 0xA,0xB,0xC to ch1 at 0x0028, pop ×3 → 0xA, 0xB, 0xC. A 4th pop → 0 and ch1 STATUS bit19=1.
- Push DEPTH+1=9 values to ch0 → the 9th is dropped, STATUS=0x60008. Pop all → first 8 values in order. Then run 3×DEPTH push/pop cycles to check pointer wraparound.
- Channel isolation: push 0x55 to ch3 (0x0038) → ch0..2 remain empty. Pop ch3 → 0x55.
- Same-cycle push + pop on a full ch2 → pop returns the oldest entry, count stays 8, no overflow. Write 0x3 to ch2 STATUS → count 0, flags clear.
- Read 0x0024 with one item present → returns head and count unchanged if PEEK_EN, else 0. Read 0x0000 → rsp_valid stays 0.
